// File: rtl/demux_1to16_8bit_reg_if.sv
// Source-side bus of the registered 1-to-16 demux: one input word plus per-channel
// holding outputs and their consume strobes.
interface demux_1to16_8bit_reg_if #(
  parameter int WIDTH = 8,
  parameter int N     = 16,
  parameter int SEL_W = 4
);
  logic [WIDTH-1:0]   I;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] Y;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ack;
  logic [7:0]         drop_cnt;

  modport master (
    output I, sel, in_valid, out_ack,
    input  in_ready, Y, out_valid, drop_cnt
  );

  modport slave (
    input  I, sel, in_valid, out_ack,
    output in_ready, Y, out_valid, drop_cnt
  );
endinterface

// File: rtl/demux_1to16_8bit_reg.sv
// Registered 1-to-16 demux: each channel holds one word until its consumer acks;
// a full channel back-pressures only writes addressed to it.
module demux_1to16_8bit_reg_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);
  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  // wr_i only fires while empty, so write and ack never collide on one channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (wr_i) data_q <= d_i;
      if (wr_i)       vld_q <= 1'b1;
      else if (ack_i) vld_q <= 1'b0;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;
endmodule

module demux_1to16_8bit_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_1to16_8bit_reg_if.slave  bus
);
  logic [N-1:0]            vld;
  logic [N-1:0]            wr;
  logic [N-1:0][WIDTH-1:0] y;
  logic                    rdy;
  logic                    accept;
  logic [7:0]              drop_q, drop_d;

  // ready looks only at registered state; an ack this cycle frees the channel next cycle
  assign rdy    = ~vld[bus.sel];
  assign accept = bus.in_valid & rdy;

  always_comb begin
    wr = '0;
    if (accept) wr[bus.sel] = 1'b1;
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    demux_1to16_8bit_reg_ch #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_i  (wr[g]),
      .d_i   (bus.I),
      .ack_i (bus.out_ack[g]),
      .q_o   (y[g]),
      .vld_o (vld[g])
    );
  end

  always_comb begin
    drop_d = drop_q;
    if (bus.in_valid && !rdy && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign bus.in_ready  = rdy;
  assign bus.Y         = y;
  assign bus.out_valid = vld;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_demux_1to16_8bit_reg.sv
// Scoreboard bench for the registered 1-to-16 demux: stimulus queues expected
// {channel,data} pairs, a monitor pops them on each channel's EMPTY->FULL edge.
module tb_demux_1to16_8bit_reg;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [11:0] exp_q[$];
  logic [15:0] prev_vld = '0;

  demux_1to16_8bit_reg_if #(.WIDTH(8), .N(16), .SEL_W(4)) bus ();

  demux_1to16_8bit_reg #(.WIDTH(8), .N(16), .SEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every new FULL channel must match the oldest outstanding write
  always @(negedge clk) begin
    for (int k = 0; k < 16; k++) begin
      if (bus.out_valid[k] === 1'b1 && prev_vld[k] !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: ch %0d data %0h with no write pending", k, bus.Y[k*8 +: 8]);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if ({k[3:0], bus.Y[k*8 +: 8]} !== e) begin
            failures++;
            $display("FAIL sb_data: got ch %0d data %0h expected ch %0d data %0h",
                     k, bus.Y[k*8 +: 8], e[11:8], e[7:0]);
          end
        end
      end
    end
    prev_vld = bus.out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.I = '0; bus.sel = '0; bus.in_valid = 1'b0; bus.out_ack = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // preload ch7 and stall one cycle so reset has something to clear
    bus.I = 8'h77; bus.sel = 4'd7; bus.in_valid = 1'b1;
    exp_q.push_back({4'd7, 8'h77});
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("pre_vld", bus.out_valid, 16'h0080);
    chk("pre_drop", bus.drop_cnt, 8'd1);

    // 1: async reset mid-cycle, no edge needed
    #2 rst_n = 1'b0;
    #1;
    chk("rst_Y", bus.Y, 128'h0);
    chk("rst_vld", bus.out_valid, 16'h0000);
    chk("rst_drop", bus.drop_cnt, 8'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 2: write A5 to ch3
    bus.I = 8'hA5; bus.sel = 4'd3; bus.in_valid = 1'b1;
    #1 chk("t2_rdy", bus.in_ready, 1'b1);
    exp_q.push_back({4'd3, 8'hA5});
    tick();
    bus.in_valid = 1'b0;
    chk("t2_vld", bus.out_valid, 16'h0008);
    chk("t2_Y3", bus.Y[31:24], 8'hA5);

    // 3: stall on full ch3 for 4 clocks
    bus.I = 8'h5A; bus.sel = 4'd3; bus.in_valid = 1'b1;
    #1 chk("t3_rdy", bus.in_ready, 1'b0);
    repeat (4) tick();
    bus.in_valid = 1'b0;
    chk("t3_Y3", bus.Y[31:24], 8'hA5);
    chk("t3_drop", bus.drop_cnt, 8'd4);

    // 4: ack and write ch3 together; write is refused, retry lands
    bus.out_ack = 16'h0008; bus.I = 8'h11; bus.sel = 4'd3; bus.in_valid = 1'b1;
    tick();
    bus.out_ack = '0;
    chk("t4_vld3_clr", bus.out_valid[3], 1'b0);
    chk("t4_Y3_keep", bus.Y[31:24], 8'hA5);
    chk("t4_drop", bus.drop_cnt, 8'd5);
    chk("t4_rdy", bus.in_ready, 1'b1);
    exp_q.push_back({4'd3, 8'h11});
    tick();
    bus.in_valid = 1'b0;
    chk("t4_vld3_set", bus.out_valid[3], 1'b1);
    chk("t4_Y3_new", bus.Y[31:24], 8'h11);

    // 5: fill ch0, then ack ch0+ch3 while writing ch15
    bus.I = 8'h0F; bus.sel = 4'd0; bus.in_valid = 1'b1;
    exp_q.push_back({4'd0, 8'h0F});
    tick();
    chk("t5_pre_vld", bus.out_valid, 16'h0009);
    bus.out_ack = 16'h0009; bus.I = 8'hC3; bus.sel = 4'd15;
    exp_q.push_back({4'd15, 8'hC3});
    tick();
    bus.in_valid = 1'b0; bus.out_ack = '0;
    chk("t5_vld", bus.out_valid, 16'h8000);
    chk("t5_Y15", bus.Y[127:120], 8'hC3);
    chk("t5_Y0_keep", bus.Y[7:0], 8'h0F);

    // ack on an empty channel changes nothing
    bus.out_ack = 16'h0020;
    tick();
    bus.out_ack = '0;
    chk("ack_empty_vld", bus.out_valid, 16'h8000);
    chk("ack_empty_drop", bus.drop_cnt, 8'd5);

    // 6: long stall on ch15 saturates drop_cnt
    bus.I = 8'hEE; bus.sel = 4'd15; bus.in_valid = 1'b1;
    repeat (249) tick();
    chk("t6_drop_254", bus.drop_cnt, 8'hFE);
    repeat (51) tick();
    chk("t6_drop_sat", bus.drop_cnt, 8'hFF);
    repeat (5) tick();
    chk("t6_drop_hold", bus.drop_cnt, 8'hFF);
    chk("t6_Y15_keep", bus.Y[127:120], 8'hC3);

    // mid-stream reset pulse
    #2 rst_n = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    chk("t6_rst_Y", bus.Y, 128'h0);
    chk("t6_rst_vld", bus.out_valid, 16'h0000);
    chk("t6_rst_drop", bus.drop_cnt, 8'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    chk("t6_post_vld", bus.out_valid, 16'h0000);

    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
